// File: rtl/spi_dac_pkg.sv
// Shared definitions for the SPI DAC loopback receiver: frame geometry,
// command/address codes, FSM states and small decode helpers.
package spi_dac_pkg;

    // Default frame length in bits.
    localparam int FRAME_BITS_DEF = 32;

    // Bit counter width and its saturation value.
    localparam int          CNT_W   = 6;
    localparam logic [5:0]  CNT_MAX = 6'd63;

    // Field positions within a received frame (bit 31 arrives first).
    localparam int CMD_HI  = 23;
    localparam int CMD_LO  = 20;
    localparam int ADDR_HI = 19;
    localparam int ADDR_LO = 16;
    localparam int DATA_HI = 15;
    localparam int DATA_LO = 4;

    // Command codes.
    localparam logic [3:0] CMD_WRITE        = 4'b0000;
    localparam logic [3:0] CMD_UPDATE       = 4'b0001;
    localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;

    // Address codes.
    localparam logic [3:0] ADDR_A   = 4'b0000;
    localparam logic [3:0] ADDR_B   = 4'b0001;
    localparam logic [3:0] ADDR_ALL = 4'b1111;

    // Receiver FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // True when the command loads the input register(s).
    function automatic logic cmd_writes(input logic [3:0] c);
        return (c == CMD_WRITE) || (c == CMD_WRITE_UPDATE);
    endfunction

    // True when the command loads the output register(s).
    function automatic logic cmd_updates(input logic [3:0] c);
        return (c == CMD_UPDATE) || (c == CMD_WRITE_UPDATE);
    endfunction

    // True when the address selects channel A.
    function automatic logic addr_hits_a(input logic [3:0] a);
        return (a == ADDR_A) || (a == ADDR_ALL);
    endfunction

    // True when the address selects channel B.
    function automatic logic addr_hits_b(input logic [3:0] a);
        return (a == ADDR_B) || (a == ADDR_ALL);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser with edge detection. Edges are suppressed until
// the chain has been refilled with real input samples after reset, so a
// line that already sits at its active level at reset release is not
// mistaken for a fresh transition.
module sync_edge_detect #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic qzt_clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;
    logic [STAGES:0]   prime_r;

    // Synchroniser chain, previous-level flop and post-reset priming shifter.
    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            sync_r  <= {STAGES{RESET_VAL}};
            prev_r  <= RESET_VAL;
            prime_r <= {(STAGES+1){1'b0}};
        end else begin
            sync_r  <= {sync_r[STAGES-2:0], din};
            prev_r  <= sync_r[STAGES-1];
            prime_r <= {prime_r[STAGES-1:0], 1'b1};
        end
    end

    assign level = sync_r[STAGES-1];
    assign rise  = prime_r[STAGES] &  sync_r[STAGES-1] & ~prev_r;
    assign fall  = prime_r[STAGES] & ~sync_r[STAGES-1] &  prev_r;

endmodule

// File: rtl/spi_dac_receiver.sv
// Oversampling SPI receiver that rebuilds the dual 12-bit DAC state
// (input and output registers of channels A and B) from command frames.
module spi_dac_receiver
    import spi_dac_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK_50M,
    input  logic        reset,
    input  logic        SPI_SCK,
    input  logic        SPI_MOSI,
    input  logic        DAC_CS,
    input  logic        DAC_CLR,
    output logic [11:0] Va,
    output logic [11:0] Vb,
    output logic [3:0]  cmd,
    output logic [3:0]  addr,
    output logic        frame_valid,
    output logic        frame_error
);

    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

    // Synchronised SPI lines.
    logic sck_level_s, sck_rise_s, sck_fall_s;
    logic cs_level_s, cs_rise_s, cs_fall_s;
    logic clr_level_s, unused_clr_rise_s, unused_clr_fall_s;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic mosi_s;

    // Receiver and DAC state.
    state_t                 state_r, state_nxt_s;
    logic [FRAME_BITS-1:0]  shift_r, shift_nxt_s;
    logic [CNT_W-1:0]       count_r, count_nxt_s;
    logic [11:0]            in_a_r, in_a_nxt_s;
    logic [11:0]            in_b_r, in_b_nxt_s;
    logic [11:0]            va_r, va_nxt_s;
    logic [11:0]            vb_r, vb_nxt_s;
    logic [3:0]             cmd_r, cmd_nxt_s;
    logic [3:0]             addr_r, addr_nxt_s;
    logic                   frame_valid_r, frame_valid_nxt_s;
    logic                   frame_error_r, frame_error_nxt_s;

    // Frame field decode.
    logic [3:0]  cmd_f_s;
    logic [3:0]  addr_f_s;
    logic [11:0] data_f_s;
    logic        wr_a_s, wr_b_s, up_a_s, up_b_s;
    logic        unused_shift_msb_s;

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .qzt_clk (CLK_50M),
        .reset   (reset),
        .din     (SPI_SCK),
        .level   (sck_level_s),
        .rise    (sck_rise_s),
        .fall    (sck_fall_s)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .qzt_clk (CLK_50M),
        .reset   (reset),
        .din     (DAC_CS),
        .level   (cs_level_s),
        .rise    (cs_rise_s),
        .fall    (cs_fall_s)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_clr (
        .qzt_clk (CLK_50M),
        .reset   (reset),
        .din     (DAC_CLR),
        .level   (clr_level_s),
        .rise    (unused_clr_rise_s),
        .fall    (unused_clr_fall_s)
    );

    // MOSI only needs its level, delayed identically to SCK.
    always_ff @(posedge CLK_50M or posedge reset) begin
        if (reset) begin
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], SPI_MOSI};
        end
    end

    assign mosi_s             = mosi_sync_r[SYNC_STAGES-1];
    assign unused_shift_msb_s = shift_r[FRAME_BITS-1] ^ sck_level_s ^ sck_fall_s ^ cs_level_s;

    assign cmd_f_s  = shift_r[CMD_HI:CMD_LO];
    assign addr_f_s = shift_r[ADDR_HI:ADDR_LO];
    assign data_f_s = shift_r[DATA_HI:DATA_LO];
    assign wr_a_s   = cmd_writes(cmd_f_s)  & addr_hits_a(addr_f_s);
    assign wr_b_s   = cmd_writes(cmd_f_s)  & addr_hits_b(addr_f_s);
    assign up_a_s   = cmd_updates(cmd_f_s) & addr_hits_a(addr_f_s);
    assign up_b_s   = cmd_updates(cmd_f_s) & addr_hits_b(addr_f_s);

    // Next-state, frame shifting and register decode.
    always_comb begin
        state_nxt_s       = state_r;
        shift_nxt_s       = shift_r;
        count_nxt_s       = count_r;
        in_a_nxt_s        = in_a_r;
        in_b_nxt_s        = in_b_r;
        va_nxt_s          = va_r;
        vb_nxt_s          = vb_r;
        cmd_nxt_s         = cmd_r;
        addr_nxt_s        = addr_r;
        frame_valid_nxt_s = 1'b0;
        frame_error_nxt_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_nxt_s = ST_SHIFT;
                    shift_nxt_s = {FRAME_BITS{1'b0}};
                    count_nxt_s = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // CS rise wins over a coincident SCK rise.
                if (cs_rise_s) begin
                    state_nxt_s = ST_CHECK;
                end else if (sck_rise_s) begin
                    shift_nxt_s = {shift_r[FRAME_BITS-2:0], mosi_s};
                    count_nxt_s = (count_r == CNT_MAX) ? count_r : (count_r + 6'd1);
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_CHECK: begin
                if (count_r == FRAME_CNT) begin
                    frame_valid_nxt_s = 1'b1;
                    cmd_nxt_s         = cmd_f_s;
                    addr_nxt_s        = addr_f_s;
                    in_a_nxt_s        = wr_a_s ? data_f_s : in_a_r;
                    in_b_nxt_s        = wr_b_s ? data_f_s : in_b_r;
                    va_nxt_s          = up_a_s ? in_a_nxt_s : va_r;
                    vb_nxt_s          = up_b_s ? in_b_nxt_s : vb_r;
                end else begin
                    frame_error_nxt_s = 1'b1;
                end
                // A new frame may start in the very cycle this one is judged.
                if (cs_fall_s) begin
                    state_nxt_s = ST_SHIFT;
                    shift_nxt_s = {FRAME_BITS{1'b0}};
                    count_nxt_s = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; a synced DAC_CLR low overrides any write.
    always_ff @(posedge CLK_50M or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            shift_r       <= {FRAME_BITS{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            in_a_r        <= 12'h000;
            in_b_r        <= 12'h000;
            va_r          <= 12'h000;
            vb_r          <= 12'h000;
            cmd_r         <= 4'h0;
            addr_r        <= 4'h0;
            frame_valid_r <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            shift_r       <= shift_nxt_s;
            count_r       <= count_nxt_s;
            cmd_r         <= cmd_nxt_s;
            addr_r        <= addr_nxt_s;
            frame_valid_r <= frame_valid_nxt_s;
            frame_error_r <= frame_error_nxt_s;
            if (clr_level_s == 1'b0) begin
                in_a_r <= 12'h000;
                in_b_r <= 12'h000;
                va_r   <= 12'h000;
                vb_r   <= 12'h000;
            end else begin
                in_a_r <= in_a_nxt_s;
                in_b_r <= in_b_nxt_s;
                va_r   <= va_nxt_s;
                vb_r   <= vb_nxt_s;
            end
        end
    end

    assign Va          = va_r;
    assign Vb          = vb_r;
    assign cmd         = cmd_r;
    assign addr        = addr_r;
    assign frame_valid = frame_valid_r;
    assign frame_error = frame_error_r;

endmodule

// File: tb/tb_spi_dac_receiver.sv
// Directed self-checking bench for spi_dac_receiver: drives SPI frames at
// 12.5 MHz SCK and compares DAC state against hand-computed values.
module tb_spi_dac_receiver;

    logic        CLK_50M  = 1'b0;
    logic        reset    = 1'b1;
    logic        SPI_SCK  = 1'b0;
    logic        SPI_MOSI = 1'b0;
    logic        DAC_CS   = 1'b1;
    logic        DAC_CLR  = 1'b1;
    logic [11:0] Va, Vb;
    logic [3:0]  cmd, addr;
    logic        frame_valid, frame_error;

    int   checks      = 0;
    int   errors      = 0;
    int   valid_total = 0;
    int   error_total = 0;
    logic both_seen   = 1'b0;
    int   v0, e0, lat;

    always #10 CLK_50M = ~CLK_50M;

    spi_dac_receiver dut (
        .CLK_50M     (CLK_50M),
        .reset       (reset),
        .SPI_SCK     (SPI_SCK),
        .SPI_MOSI    (SPI_MOSI),
        .DAC_CS      (DAC_CS),
        .DAC_CLR     (DAC_CLR),
        .Va          (Va),
        .Vb          (Vb),
        .cmd         (cmd),
        .addr        (addr),
        .frame_valid (frame_valid),
        .frame_error (frame_error)
    );

    // Pulse counters sampled on the inactive edge.
    always @(negedge CLK_50M) begin
        if (frame_valid === 1'b1) valid_total <= valid_total + 1;
        if (frame_error === 1'b1) error_total <= error_total + 1;
        if (frame_valid === 1'b1 && frame_error === 1'b1) both_seen <= 1'b1;
    end

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] a, input logic [11:0] d);
        return {8'h00, c, a, d, 4'h0};
    endfunction

    // Pull CS low and clock out the low n bits of v, MSB first.
    task automatic send_bits(input logic [127:0] v, input int n);
        DAC_CS = 1'b0;
        repeat (2) @(negedge CLK_50M);
        for (int i = n - 1; i >= 0; i--) begin
            SPI_MOSI = v[i];
            SPI_SCK  = 1'b0;
            repeat (2) @(negedge CLK_50M);
            SPI_SCK  = 1'b1;
            repeat (2) @(negedge CLK_50M);
        end
        SPI_SCK = 1'b0;
        repeat (2) @(negedge CLK_50M);
    endtask

    // Raise CS and report in which cycle frame_valid first appears (0 = never).
    task automatic end_frame(output int first_valid);
        DAC_CS      = 1'b1;
        first_valid = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK_50M);
            if (frame_valid === 1'b1 && first_valid == 0) first_valid = c;
        end
        @(negedge CLK_50M);
    endtask

    initial begin
        repeat (3) @(negedge CLK_50M);
        check("rst_Va",   {20'h0, Va},   32'h0);
        check("rst_Vb",   {20'h0, Vb},   32'h0);
        check("rst_cmd",  {28'h0, cmd},  32'h0);
        check("rst_addr", {28'h0, addr}, 32'h0);
        check("rst_fv",   {31'h0, frame_valid}, 32'h0);
        check("rst_fe",   {31'h0, frame_error}, 32'h0);
        reset = 1'b0;
        repeat (6) @(negedge CLK_50M);

        // Write+update A with 0xABC; latency from CS rise must be 4 cycles.
        v0 = valid_total; e0 = error_total;
        send_bits({96'h0, mk(4'h3, 4'h0, 12'hABC)}, 32);
        end_frame(lat);
        check("t1_latency", lat, 32'd4);
        check("t1_valid_cnt", valid_total - v0, 32'd1);
        check("t1_error_cnt", error_total - e0, 32'd0);
        check("t1_Va", {20'h0, Va}, 32'hABC);
        check("t1_Vb", {20'h0, Vb}, 32'h000);
        check("t1_cmd", {28'h0, cmd}, 32'h3);
        check("t1_addr", {28'h0, addr}, 32'h0);

        // Write both input regs with 0x123, outputs unchanged until update B.
        send_bits({96'h0, mk(4'h0, 4'hF, 12'h123)}, 32);
        end_frame(lat);
        check("t2a_Va", {20'h0, Va}, 32'hABC);
        check("t2a_Vb", {20'h0, Vb}, 32'h000);
        check("t2a_addr", {28'h0, addr}, 32'hF);
        send_bits({96'h0, mk(4'h1, 4'h1, 12'h000)}, 32);
        end_frame(lat);
        check("t2b_Va", {20'h0, Va}, 32'hABC);
        check("t2b_Vb", {20'h0, Vb}, 32'h123);
        check("t2b_cmd", {28'h0, cmd}, 32'h1);

        // Short, long and very long frames: errors only, no register change.
        v0 = valid_total; e0 = error_total;
        send_bits({96'h0, mk(4'h3, 4'hF, 12'hEEE) >> 1}, 31);
        end_frame(lat);
        check("t3_short_err", error_total - e0, 32'd1);
        e0 = error_total;
        send_bits({95'h0, mk(4'h3, 4'hF, 12'hEEE), 1'b0}, 33);
        end_frame(lat);
        check("t3_long_err", error_total - e0, 32'd1);
        e0 = error_total;
        send_bits({96'h0, mk(4'h3, 4'hF, 12'hEEE)}, 96);
        end_frame(lat);
        check("t3_sat_err", error_total - e0, 32'd1);
        check("t3_valid_cnt", valid_total - v0, 32'd0);
        check("t3_Va", {20'h0, Va}, 32'hABC);
        check("t3_Vb", {20'h0, Vb}, 32'h123);
        check("t3_cmd", {28'h0, cmd}, 32'h1);

        // Va = 0xFFF, then DAC_CLR low across the CHECK of a write frame.
        send_bits({96'h0, mk(4'h3, 4'h0, 12'hFFF)}, 32);
        end_frame(lat);
        check("t4_Va_fff", {20'h0, Va}, 32'hFFF);
        v0 = valid_total;
        send_bits({96'h0, mk(4'h3, 4'hF, 12'h555)}, 32);
        DAC_CS  = 1'b1;
        DAC_CLR = 1'b0;
        repeat (3) @(negedge CLK_50M);
        DAC_CLR = 1'b1;
        repeat (8) @(negedge CLK_50M);
        check("t4_clr_valid", valid_total - v0, 32'd1);
        check("t4_clr_Va", {20'h0, Va}, 32'h000);
        check("t4_clr_Vb", {20'h0, Vb}, 32'h000);
        send_bits({96'h0, mk(4'h1, 4'hF, 12'h000)}, 32);
        end_frame(lat);
        check("t4_upd_Va", {20'h0, Va}, 32'h000);
        check("t4_upd_Vb", {20'h0, Vb}, 32'h000);

        // Back-to-back frames with CS high for a single cycle.
        v0 = valid_total;
        send_bits({96'h0, mk(4'h3, 4'h0, 12'h111)}, 32);
        DAC_CS = 1'b1;
        @(negedge CLK_50M);
        send_bits({96'h0, mk(4'h3, 4'h1, 12'h222)}, 32);
        end_frame(lat);
        check("t5_valid_cnt", valid_total - v0, 32'd2);
        check("t5_Va", {20'h0, Va}, 32'h111);
        check("t5_Vb", {20'h0, Vb}, 32'h222);

        // Reset mid-frame with CS held low: partial frame must vanish.
        v0 = valid_total; e0 = error_total;
        send_bits({96'h0, mk(4'h3, 4'hF, 12'hABC) >> 16}, 16);
        reset = 1'b1;
        repeat (2) @(negedge CLK_50M);
        reset = 1'b0;
        send_bits({112'h0, 16'hABC0}, 16);
        end_frame(lat);
        check("t6_no_valid", valid_total - v0, 32'd0);
        check("t6_no_error", error_total - e0, 32'd0);
        check("t6_Va_rst", {20'h0, Va}, 32'h000);
        send_bits({96'h0, mk(4'h3, 4'h1, 12'h7FF)}, 32);
        end_frame(lat);
        check("t6_Vb", {20'h0, Vb}, 32'h7FF);
        check("t6_Va", {20'h0, Va}, 32'h000);
        check("t6_addr", {28'h0, addr}, 32'h1);

        check("never_both_pulses", {31'h0, both_seen}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_dac_receiver.md
# spi_dac_receiver

Receives the 32-bit SPI command frames that drive the board's dual 12-bit DAC and reconstructs the DAC channel state: the A/B input registers and the output (update) registers. It sits on the far side of the SPI_SCK/SPI_MOSI/DAC_CS/DAC_CLR lines, on the same CLK_50M domain as the waveform generators. It is used as an on-chip loopback monitor and as the bench's reference model of the DAC. All SPI inputs are oversampled; SPI_SCK is treated as data, never as a clock.

## Interface
- FRAME_BITS, 32, bits per valid frame
- SYNC_STAGES, 2, synchroniser flops per SPI input (≥2)
- CLK_50M  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high; clears all state
- SPI_SCK  in  1  serial clock; MOSI sampled on its rising edge
- SPI_MOSI  in  1  serial data, MSB first
- DAC_CS  in  1  frame select, active low
- DAC_CLR  in  1  asynchronous-style clear from the master, active low (synchronised here)
- Va  out  12  channel A output register
- Vb  out  12  channel B output register
- cmd  out  4  command field of the last accepted frame
- addr  out  4  address field of the last accepted frame
- frame_valid  out  1  one-cycle pulse per accepted frame
- frame_error  out  1  one-cycle pulse per frame with bit count ≠ FRAME_BITS

## Operation
- Frame layout (bit 31 first): [31:24] ignored, [23:20] cmd, [19:16] addr, [15:4] data, [3:0] ignored.
- Commands: 0000 write input reg(addr); 0001 update output reg(addr) from input reg; 0011 write input reg and update output reg(addr); any other code accepted (frame_valid) with no register change.
- Addresses: 0000 = A, 0001 = B, 1111 = both; any other address has no register effect.
- States: IDLE, SHIFT, CHECK.
  - IDLE: wait for synced DAC_CS falling edge → clear shift reg and bit counter, go SHIFT.
  - SHIFT: each synced SPI_SCK rising edge shifts SPI_MOSI into bit 0 of 32-bit shift reg; bit counter increments, saturating at 63. Synced DAC_CS rising edge → CHECK.
  - CHECK (one cycle): count == FRAME_BITS → decode, update regs, pulse frame_valid, latch cmd/addr; otherwise pulse frame_error, no register change. Next state IDLE, or SHIFT if a DAC_CS falling edge is detected in this cycle.
- DAC_CLR low (synced): Va, Vb and both input regs forced to 0 every cycle it is low; overrides any CHECK write in the same cycle; frame reception continues.

## Timing
- Reset values: Va=0, Vb=0, input regs=0, cmd=0, addr=0, frame_valid=0, frame_error=0, state IDLE; synchroniser flops reset to idle levels (CS=1, SCK=0, CLR=1, MOSI=0).
- Requirement on master: SPI_SCK high and low phases each ≥2 CLK_50M cycles (12.5 MHz SCK is the maximum); MOSI stable across the synced sample point.
- Latency: raw DAC_CS rise → Va/Vb/cmd/addr update and frame_valid high = SYNC_STAGES+2 cycles (4 at default).
- SCK rising edge detected in the same cycle as the CS rising edge: ignored (CS wins).
- SCK edges while CS high: ignored. Frames >63 bits: counter saturates, frame_error.
- Reset asserted mid-frame: partial frame discarded; after release, block leaves IDLE only on a fresh CS falling edge (CS already low at release is not a frame start).
- frame_valid and frame_error never high together; each exactly one cycle.

## Structure
- Package spi_dac_pkg: FRAME_BITS default, field bit positions, command codes (CMD_WRITE, CMD_UPDATE, CMD_WRITE_UPDATE), address codes (ADDR_A, ADDR_B, ADDR_ALL), state enum.
- Sub-module sync_edge_detect: SYNC_STAGES-flop synchroniser with reset value parameter, outputs level, rise, fall; instantiated for SPI_SCK, DAC_CS, DAC_CLR (MOSI uses level only).

## Test plan
- Frame cmd 0011, addr 0000, data 12'hABC at 12.5 MHz SCK → Va=12'hABC, Vb=0, frame_valid once, 4 cycles after CS rise.
- cmd 0000 addr 1111 data 12'h123, then cmd 0001 addr 0001 → Va unchanged 0, Vb=12'h123 only after second frame.
- 31-bit and 33-bit frames with cmd 0011 → frame_error pulse each, Va/Vb unchanged, frame_valid stays 0.
- DAC_CLR low for 3 cycles after Va=12'hFFF, including a cycle coinciding with CHECK of a write frame → Va=Vb=0.
- reset pulsed at bit 16 of a frame with CS held low, then CS rises and a full frame 0011/0001/12'h7FF follows → first partial frame produces no pulse; Vb=12'h7FF.
- Back-to-back frames with CS high for exactly 1 synced cycle → both frames accepted, two frame_valid pulses.
